// File: rtl/sr_pkg.sv
// Shared definitions for the SR flop bank: S=R=1 policy codes and the per-cell next-state rule.
package sr_pkg;

  localparam int unsigned SR_RST_DOM = 0;
  localparam int unsigned SR_SET_DOM = 1;
  localparam int unsigned SR_HOLD    = 2;
  localparam int unsigned SR_TOGGLE  = 3;

  function automatic logic sr_next(input int unsigned mode, input logic s, input logic r,
                                   input logic q);
    logic nxt;
    nxt = q;
    unique case ({s, r})
      2'b00: nxt = q;
      2'b10: nxt = 1'b1;
      2'b01: nxt = 1'b0;
      2'b11: begin
        case (mode)
          SR_RST_DOM: nxt = 1'b0;
          SR_SET_DOM: nxt = 1'b1;
          SR_HOLD:    nxt = q;
          SR_TOGGLE:  nxt = ~q;
          default:    nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One clocked SR storage cell with enable gating and a one-cycle change pulse.
module sr_cell
  import sr_pkg::*;
#(
  parameter int unsigned MODE = SR_RST_DOM
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic chg
);

  logic q_d, q_q;
  logic chg_d, chg_q;

  always_comb begin
    q_d   = q_q;
    chg_d = 1'b0;
    if (en) begin
      q_d = sr_next(MODE, s, r, q_q);
    end
    chg_d = q_d ^ q_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q   <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
    end
  end

  assign q   = q_q;
  assign chg = chg_q;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of CH clocked SR cells with a shared enable, sticky conflict flag and saturating
// conflict counter.
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int unsigned CH    = 8,
  parameter int unsigned MODE  = SR_RST_DOM,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CH-1:0]    s,
  input  logic [CH-1:0]    r,
  input  logic             clr_err,
  output logic [CH-1:0]    q,
  output logic [CH-1:0]    qn,
  output logic [CH-1:0]    chg,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (MODE > SR_TOGGLE) begin : g_bad_mode
    $error("sr_ff_bank: MODE must be 0..3");
  end
  if (CH < 1) begin : g_bad_ch
    $error("sr_ff_bank: CH must be at least 1");
  end
  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("sr_ff_bank: CNT_W must be at least 2");
  end

  for (genvar i = 0; i < CH; i++) begin : g_cell
    sr_cell #(.MODE(MODE)) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .s    (s[i]),
      .r    (r[i]),
      .q    (q[i]),
      .chg  (chg[i])
    );
  end

  // qn is a straight inverter of the cell flops, so q=qn=1 can never appear.
  assign qn = ~q;

  logic             conflict;
  logic             err_d, err_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign conflict = en & (|(s & r));

  // A conflict in the same cycle as clr_err restarts the count at one.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (conflict) begin
      err_d = 1'b1;
      if (clr_err) begin
        cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (clr_err) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Scoreboard bench: four banks (MODE 0..3, CNT_W=2) share stimulus; each directed step
// pushes hand-computed expectations that a monitor pops and compares after the edge.
module tb_sr_ff_bank;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] s;
  logic [7:0] r;
  logic       clr_err;

  logic [7:0] q_a   [4];
  logic [7:0] qn_a  [4];
  logic [7:0] chg_a [4];
  logic       err_a [4];
  logic [1:0] cnt_a [4];

  for (genvar m = 0; m < 4; m++) begin : g_dut
    sr_ff_bank #(.CH(8), .MODE(m), .CNT_W(2)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .s      (s),
      .r      (r),
      .clr_err(clr_err),
      .q      (q_a[m]),
      .qn     (qn_a[m]),
      .chg    (chg_a[m]),
      .err    (err_a[m]),
      .err_cnt(cnt_a[m])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [3:0][7:0] q;
    logic [3:0][7:0] chg;
    logic            err;
    logic [1:0]      cnt;
  } exp_t;

  exp_t            sb[$];
  logic [3:0][7:0] prev_q;
  int              checks = 0;
  int              errors = 0;

  task automatic chk(input string nm, input int m, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s mode%0d: got %h expected %h", nm, m, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue what the next rising edge must produce.
  task automatic step(input string nm, input logic rst_v, input logic en_v, input logic [7:0] s_v,
                      input logic [7:0] r_v, input logic clr_v, input logic [7:0] q0,
                      input logic [7:0] q1, input logic [7:0] q2, input logic [7:0] q3,
                      input logic err_v, input logic [1:0] cnt_v);
    exp_t e;
    @(negedge clk);
    rst_n   = rst_v;
    en      = en_v;
    s       = s_v;
    r       = r_v;
    clr_err = clr_v;
    e.name = nm;
    e.q    = {q3, q2, q1, q0};
    for (int m = 0; m < 4; m++) e.chg[m] = rst_v ? (e.q[m] ^ prev_q[m]) : 8'h00;
    e.err  = err_v;
    e.cnt  = cnt_v;
    prev_q = e.q;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        for (int m = 0; m < 4; m++) begin
          chk({e.name, " q"}, m, q_a[m], e.q[m]);
          chk({e.name, " qn"}, m, qn_a[m], ~e.q[m]);
          chk({e.name, " chg"}, m, chg_a[m], e.chg[m]);
          chk({e.name, " err"}, m, {7'd0, err_a[m]}, {7'd0, e.err});
          chk({e.name, " err_cnt"}, m, {6'd0, cnt_a[m]}, {6'd0, e.cnt});
        end
      end
    end
  end

  initial begin : stim
    int budget;
    rst_n = 1'b0; en = 1'b1; s = 8'hFF; r = 8'h00; clr_err = 1'b0;
    prev_q = '0;
    //    name        rst en  s      r      clr  q m0   q m1   q m2   q m3   err  cnt
    step("reset1",    0, 1, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'd0);
    step("reset2",    0, 1, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'd0);
    step("set0f",     1, 1, 8'h0F, 8'h00, 0, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 0, 2'd0);
    step("hold",      1, 1, 8'h00, 8'h00, 0, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 0, 2'd0);
    step("rst03",     1, 1, 8'h00, 8'h03, 0, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 0, 2'd0);
    step("gate1",     1, 0, 8'hFF, 8'h01, 0, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 0, 2'd0);
    step("gate2",     1, 0, 8'hFF, 8'h01, 0, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 0, 2'd0);
    step("gate3",     1, 0, 8'hFF, 8'h01, 0, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 0, 2'd0);
    step("reload0f",  1, 1, 8'h03, 8'h00, 0, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 0, 2'd0);
    step("policy",    1, 1, 8'h11, 8'h11, 0, 8'h0E, 8'h1F, 8'h0F, 8'h1E, 1, 2'd1);
    step("clr1",      1, 1, 8'h00, 8'h00, 1, 8'h0E, 8'h1F, 8'h0F, 8'h1E, 0, 2'd0);
    step("sat1",      1, 1, 8'h80, 8'h80, 0, 8'h0E, 8'h9F, 8'h0F, 8'h9E, 1, 2'd1);
    step("sat2",      1, 1, 8'h80, 8'h80, 0, 8'h0E, 8'h9F, 8'h0F, 8'h1E, 1, 2'd2);
    step("sat3",      1, 1, 8'h80, 8'h80, 0, 8'h0E, 8'h9F, 8'h0F, 8'h9E, 1, 2'd3);
    step("sat4",      1, 1, 8'h80, 8'h80, 0, 8'h0E, 8'h9F, 8'h0F, 8'h1E, 1, 2'd3);
    step("sat5",      1, 1, 8'h80, 8'h80, 0, 8'h0E, 8'h9F, 8'h0F, 8'h9E, 1, 2'd3);
    step("clr2",      1, 1, 8'h00, 8'h00, 1, 8'h0E, 8'h9F, 8'h0F, 8'h9E, 0, 2'd0);
    step("clr_conf",  1, 1, 8'h80, 8'h80, 1, 8'h0E, 8'h9F, 8'h0F, 8'h1E, 1, 2'd1);
    step("conf_b0",   1, 1, 8'h01, 8'h01, 0, 8'h0E, 8'h9F, 8'h0F, 8'h1F, 1, 2'd2);
    step("load_aa",   1, 1, 8'hAA, 8'h55, 0, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 1, 2'd2);
    step("mid_reset", 0, 1, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'd0);
    step("post_rst",  1, 1, 8'h0F, 8'h00, 0, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 0, 2'd0);
    step("swap",      1, 1, 8'hF0, 8'h0F, 0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 0, 2'd0);
    @(negedge clk);
    en = 1'b0; s = 8'h00; r = 8'h00;
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
